// File: rtl/r16_agu_param_if.sv
// r16_agu_param_if: controller-side handshake and address bus of the radix-16 FFT address generator.
interface r16_agu_param_if #(
  parameter int LOG2_N   = 16,
  parameter int SC_WIDTH = 3
);
  localparam int BC_WIDTH = LOG2_N - 4;
  logic                start;
  logic                mode;
  logic                stall;
  logic                busy;
  logic                done;
  logic                addr_valid;
  logic                BN_out;
  logic [BC_WIDTH-2:0] MA;
  logic [BC_WIDTH-1:0] ROMA;
  logic [SC_WIDTH-1:0] stage_out;
  logic                last_stage;
  logic [3:0]          RDC_sel_out;
  logic [BC_WIDTH-1:0] dtfag_idx;
  modport master (
    output start, mode, stall,
    input  busy, done, addr_valid, BN_out, MA, ROMA, stage_out, last_stage, RDC_sel_out, dtfag_idx
  );
  modport slave (
    input  start, mode, stall,
    output busy, done, addr_valid, BN_out, MA, ROMA, stage_out, last_stage, RDC_sel_out, dtfag_idx
  );
endinterface

// File: rtl/r16_agu_param.sv
// r16_agu_param: radix-16 FFT address generator (bank, word, twiddle addresses per butterfly).
// Define AGU_GRAY_EN to Gray-code the upper butterfly field in FFT mode.
module r16_agu_param #(
  parameter int LOG2_N    = 16,
  parameter int NUM_STAGE = LOG2_N / 4,
  parameter int BC_WIDTH  = LOG2_N - 4,
  parameter int SC_WIDTH  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  r16_agu_param_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t              state;
  logic [BC_WIDTH-1:0] cnt, bc, rot, rev, bc_rr, roma_n;
  logic [SC_WIDTH-1:0] sc;
  logic [SC_WIDTH+1:0] sh;
  logic                mode_q, last;
  assign sh   = {sc, 2'b00};
  assign last = !mode_q && sc == SC_WIDTH'(NUM_STAGE - 1);
  generate
    if (BC_WIDTH > 4) begin : g_field
      logic [BC_WIDTH-5:0] up;
`ifdef AGU_GRAY_EN
      assign up = cnt[BC_WIDTH-1:4] ^ (cnt[BC_WIDTH-1:4] >> 1);
`else
      assign up = cnt[BC_WIDTH-1:4];
`endif
      assign bc = {cnt[3:0], up};
    end else begin : g_digit
      assign bc = cnt;
    end
  endgenerate
  always_comb begin
    rev = '0;
    for (int i = 0; i < BC_WIDTH / 4; i++) rev[4*i +: 4] = cnt[BC_WIDTH-4-4*i +: 4];
    rot    = (bc >> sh) | (bc << (BC_WIDTH - int'(sh)));
    bc_rr  = mode_q ? rev : last ? bc : rot;
    roma_n = (mode_q || last) ? '0 : bc_rr << sh;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      sc              <= '0;
      mode_q          <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.addr_valid  <= 1'b0;
      bus.BN_out      <= 1'b0;
      bus.MA          <= '0;
      bus.ROMA        <= '0;
      bus.stage_out   <= '0;
      bus.last_stage  <= 1'b0;
      bus.RDC_sel_out <= '0;
      bus.dtfag_idx   <= '0;
    end else begin
      bus.done       <= state == DONE;
      bus.addr_valid <= state == RUN && !bus.stall;
      case (state)
        IDLE: if (bus.start) begin
          state    <= RUN;
          bus.busy <= 1'b1;
          cnt      <= '0;
          sc       <= '0;
          mode_q   <= bus.mode;
        end
        RUN: if (!bus.stall) begin
          bus.BN_out      <= ^bc_rr;
          bus.MA          <= bc_rr[BC_WIDTH-1:1];
          bus.ROMA        <= roma_n;
          bus.stage_out   <= sc;
          bus.last_stage  <= last;
          bus.RDC_sel_out <= cnt[3:0];
          bus.dtfag_idx   <= cnt;
          cnt             <= cnt + 1'b1;
          // all-ones count is the last butterfly of a stage
          if (&cnt) begin
            sc <= sc + 1'b1;
            if (mode_q || last) begin
              state    <= DONE;
              bus.busy <= 1'b0;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_r16_agu_param.sv
// tb_r16_agu_param: directed checks of the radix-16 address generator at LOG2_N=12.
module tb_r16_agu_param;
  logic clk, rst_n;
  int checks = 0;
  int fails  = 0;
  r16_agu_param_if #(.LOG2_N(12)) bus();
  r16_agu_param #(.LOG2_N(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  wire [23:0] fields = {bus.BN_out, bus.MA, bus.ROMA, bus.last_stage, bus.stage_out, bus.RDC_sel_out};
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  task automatic start_pass(input logic m);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; bus.start = 1'b0; bus.mode = 1'b0; bus.stall = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({fields, bus.dtfag_idx, bus.busy, bus.done, bus.addr_valid} !== 35'd0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", {fields, bus.dtfag_idx, bus.busy, bus.done, bus.addr_valid});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.addr_valid, bus.done} !== 3'b000) begin
      fails++; $display("FAIL idle_quiet: got %b expected 000", {bus.busy, bus.addr_valid, bus.done});
    end
  endtask
  task automatic test_fft;
    int n = 0, seq_bad = 0, last_v = -1, done_at = -1;
    logic [23:0] exp;
    bit chk;
    start_pass(1'b0);
    checks++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL fft_busy: got %b expected 1", bus.busy); end
    for (int cyc = 0; cyc < 1000 && done_at < 0; cyc++) begin
      @(negedge clk);
      if (bus.addr_valid) begin
        if (bus.dtfag_idx !== 8'(n % 256) || bus.stage_out !== 3'(n / 256)) seq_bad++;
        chk = 1'b1;
        case ({bus.stage_out[1:0], bus.dtfag_idx})
          {2'd0, 8'h12}: exp = {1'b0, 7'h10, 8'h21, 1'b0, 3'd0, 4'h2};
          {2'd1, 8'h12}: exp = {1'b0, 7'h09, 8'h20, 1'b0, 3'd1, 4'h2};
          {2'd2, 8'h12}: exp = {1'b0, 7'h10, 8'h00, 1'b1, 3'd2, 4'h2};
          {2'd0, 8'h07}: exp = {1'b1, 7'h38, 8'h70, 1'b0, 3'd0, 4'h7};
          {2'd1, 8'h07}: exp = {1'b1, 7'h03, 8'h70, 1'b0, 3'd1, 4'h7};
          {2'd2, 8'h07}: exp = {1'b1, 7'h38, 8'h00, 1'b1, 3'd2, 4'h7};
`ifdef AGU_GRAY_EN
          {2'd0, 8'h30}: exp = {1'b1, 7'h01, 8'h02, 1'b0, 3'd0, 4'h0};
`else
          {2'd0, 8'h30}: exp = {1'b0, 7'h01, 8'h03, 1'b0, 3'd0, 4'h0};
`endif
          default: chk = 1'b0;
        endcase
        if (chk) begin
          checks++;
          if (fields !== exp) begin
            fails++; $display("FAIL fft_fields[sc %0d cnt %h]: got %h expected %h", bus.stage_out, bus.dtfag_idx, fields, exp);
          end
        end
        n++; last_v = cyc;
      end
      if (bus.done) done_at = cyc;
    end
    checks++;
    if (n !== 768) begin fails++; $display("FAIL fft_count: got %0d expected 768", n); end
    checks++;
    if (seq_bad !== 0) begin fails++; $display("FAIL fft_sequence: got %0d bad expected 0", seq_bad); end
    checks++;
    if (done_at < 0 || done_at !== last_v + 1) begin fails++; $display("FAIL fft_done_timing: got %0d expected %0d", done_at, last_v + 1); end
    checks++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL fft_busy_after: got %b expected 0", bus.busy); end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL fft_done_pulse: got %b expected 0", bus.done); end
  endtask
  task automatic test_readout;
    int n = 0, seq_bad = 0, last_v = -1, done_at = -1;
    logic [23:0] exp;
    bit chk;
    start_pass(1'b1);
    for (int cyc = 0; cyc < 1000 && done_at < 0; cyc++) begin
      @(negedge clk);
      if (bus.addr_valid) begin
        if (bus.dtfag_idx !== 8'(n) || bus.stage_out !== 3'd0) seq_bad++;
        chk = 1'b1;
        case (bus.dtfag_idx)
          8'h12:   exp = {1'b0, 7'h10, 8'h00, 1'b0, 3'd0, 4'h2};
          8'h07:   exp = {1'b1, 7'h38, 8'h00, 1'b0, 3'd0, 4'h7};
          8'h30:   exp = {1'b0, 7'h01, 8'h00, 1'b0, 3'd0, 4'h0};
          8'h5A:   exp = {1'b0, 7'h52, 8'h00, 1'b0, 3'd0, 4'hA};
          default: chk = 1'b0;
        endcase
        if (chk) begin
          checks++;
          if (fields !== exp) begin
            fails++; $display("FAIL readout_fields[cnt %h]: got %h expected %h", bus.dtfag_idx, fields, exp);
          end
        end
        n++; last_v = cyc;
      end
      if (bus.done) done_at = cyc;
    end
    checks++;
    if (n !== 256) begin fails++; $display("FAIL readout_count: got %0d expected 256", n); end
    checks++;
    if (seq_bad !== 0) begin fails++; $display("FAIL readout_sequence: got %0d bad expected 0", seq_bad); end
    checks++;
    if (done_at < 0 || done_at !== last_v + 1) begin fails++; $display("FAIL readout_done_timing: got %0d expected %0d", done_at, last_v + 1); end
  endtask
  task automatic test_stall;
    int n = 0, seq_bad = 0, stl = 0, done_at = -1;
    bit did = 1'b0;
`ifdef AGU_GRAY_EN
    logic [32:0] frz = {1'b0, 8'h40, 1'b0, 7'h03, 8'h06, 1'b0, 3'd0, 4'h0};
`else
    logic [32:0] frz = {1'b0, 8'h40, 1'b1, 7'h02, 8'h04, 1'b0, 3'd0, 4'h0};
`endif
    bus.stall = 1'b1;
    start_pass(1'b0);
    checks++;
    if ({bus.busy, bus.addr_valid} !== 2'b10) begin fails++; $display("FAIL stall_start: got %b expected 10", {bus.busy, bus.addr_valid}); end
    @(negedge clk);
    checks++;
    if (bus.addr_valid !== 1'b0) begin fails++; $display("FAIL stall_start_hold: got %b expected 0", bus.addr_valid); end
    bus.stall = 1'b0;
    for (int cyc = 0; cyc < 1200 && done_at < 0; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      if (stl > 0) begin
        checks++;
        if ({bus.addr_valid, bus.dtfag_idx, fields} !== frz) begin
          fails++; $display("FAIL stall_frozen: got %h expected %h", {bus.addr_valid, bus.dtfag_idx, fields}, frz);
        end
        stl--;
        if (stl == 0) bus.stall = 1'b0;
      end else if (bus.addr_valid) begin
        if (bus.dtfag_idx !== 8'(n % 256) || bus.stage_out !== 3'(n / 256)) seq_bad++;
        if (bus.dtfag_idx == 8'h40 && bus.stage_out == 3'd0 && !did) begin
          bus.stall = 1'b1; stl = 5; did = 1'b1;
        end
        if (bus.dtfag_idx == 8'h80 && bus.stage_out == 3'd0) begin
          bus.start = 1'b1; bus.mode = 1'b1;
        end
        n++;
      end
      if (bus.done) done_at = cyc;
    end
    checks++;
    if (n !== 768) begin fails++; $display("FAIL stall_count: got %0d expected 768", n); end
    checks++;
    if (seq_bad !== 0 || done_at < 0) begin fails++; $display("FAIL stall_sequence: got %0d bad done_at %0d expected 0 bad and done", seq_bad, done_at); end
  endtask
  task automatic test_reset_abort;
    bit found = 1'b0, saw_done = 1'b0;
    int done_at = -1;
    start_pass(1'b0);
    for (int cyc = 0; cyc < 1000 && !found; cyc++) begin
      @(negedge clk);
      if (bus.addr_valid && bus.dtfag_idx == 8'h80 && bus.stage_out == 3'd1) found = 1'b1;
    end
    checks++;
    if (!found) begin fails++; $display("FAIL abort_reach: got not found expected cnt 80 sc 1"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fields, bus.dtfag_idx, bus.busy, bus.done, bus.addr_valid} !== 35'd0) begin
      fails++; $display("FAIL abort_outputs: got %h expected 0", {fields, bus.dtfag_idx, bus.busy, bus.done, bus.addr_valid});
    end
    repeat (3) begin @(negedge clk); if (bus.done) saw_done = 1'b1; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (bus.done) saw_done = 1'b1; end
    checks++;
    if (saw_done) begin fails++; $display("FAIL abort_no_done: got done expected none"); end
    start_pass(1'b0);
    @(negedge clk);
    checks++;
    if ({bus.addr_valid, bus.dtfag_idx, fields} !== {1'b1, 8'h00, 24'h0}) begin
      fails++; $display("FAIL abort_restart: got %h expected %h", {bus.addr_valid, bus.dtfag_idx, fields}, {1'b1, 8'h00, 24'h0});
    end
    for (int cyc = 0; cyc < 1000 && done_at < 0; cyc++) begin
      @(negedge clk);
      if (bus.done) done_at = cyc;
    end
    checks++;
    if (done_at < 0) begin fails++; $display("FAIL abort_restart_done: got none expected done"); end
  endtask
  initial begin
    test_reset();
    test_fft();
    test_readout();
    test_stall();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
